s25fl256s_spi_flash: RTL and testbench
======================================

Name: s25fl256s_spi_flash

Overview:
Behavioural-synthesizable SPI NOR flash slave modelled on the S25FL256S command set, scaled-down array. Supports a small single-I/O command subset (WREN/WRDI/RDSR1/READ/PP), status register with WIP/WEL, and a timed program busy phase. Used as the flash device in SPI-controller system benches; SPI pins are oversampled by a fast system clock.

Parameters:
ADDR_W, 12, array address width; array = 2^ADDR_W bytes (24-bit SPI address, upper bits ignored)
PAGE_W, 8, page size = 2^PAGE_W bytes (256)
PROG_CYCLES, 1000, clk cycles WIP stays set after page-program commit
ERASE_CYCLES, 4000, clk cycles WIP stays set after sector erase (optional feature only)

Ports:
clk  input  1  system clock; must be ≥8x SCK frequency
rst  input  1  synchronous, active-high reset
SCK  input  1  SPI clock, idles high (mode 3)
CSNeg  input  1  chip select, active low
SI  input  1  serial data in
SO  output  1  serial data out; 1'bz when not driving
RSTNeg  input  1  pin reset, active low; synchronised, then OR'd into rst behaviour
WPNeg  input  1  write protect; unused (no SR protection implemented)
HOLDNeg  input  1  hold; unused, must be tied high

Behaviour:
- SCK, CSNeg, SI pass 2-flop synchronisers; rising/falling SCK edges detected in clk domain.
- Reset (rst or RSTNeg low): SR1=0x00, state IDLE, SO=z, WIP/WEL=0. Array is NOT cleared by reset; array initialises to 0xFF at time zero. Reset mid-program aborts; bytes already written stay.
- Framing: CSNeg falling starts a command; CSNeg rising ends it from any state, returns to IDLE, SO=z.
- SI sampled on SCK rising edge, MSB first. SO updated on SCK falling edge, MSB first; first output bit driven on the falling edge after the last command/address bit.
- States: IDLE, CMD (8 bits), ADDR (24 bits), DATA_IN, DATA_OUT, BUSY.
- Opcodes:
  0x06 WREN: WEL=1 at CS rise.
  0x04 WRDI: WEL=0 at CS rise.
  0x05 RDSR1: output SR1 continuously (repeats each byte, reflects live WIP). SR1 = {6'b0, WEL, WIP}.
  0x03 READ: 3 address bytes, then stream Mem[addr], addr increments, wraps at 2^ADDR_W-1 -> 0.
  0x02 PP: 3 address bytes, data bytes captured into page buffer; column wraps inside page (upper address bits fixed). Only complete bytes count; partial trailing byte discarded. Commit at CS rise only if WEL=1 and ≥1 full byte; otherwise no effect.
  Unknown opcodes: ignored until CS rise.
- Program: Mem[a] <= Mem[a] & data (bits only 1->0). On commit WIP=1; buffered bytes written one per clk; WIP held total PROG_CYCLES clk; at end WIP=0, WEL=0.
- While WIP=1 only RDSR1 is honoured; all other opcodes ignored (WREN included).
- Array register named Mem, byte-indexed, for hierarchical monitoring.

Optional Feature:
Macro S25FL_SECTOR_ERASE_EN. Defined: opcode 0x20 + 3 address bytes, with WEL=1, at CS rise sets every byte of the 4 KB sector (whole array if smaller) to 0xFF, WIP held ERASE_CYCLES, then WIP=0, WEL=0. Undefined: 0x20 treated as unknown opcode, no array change.

Test Plan:
- Reset then RDSR1 (05 FF) -> SO returns 0x00; READ 0x000000 three bytes -> FF FF FF.
- WREN (06), CS high, RDSR1 -> 0x02; WRDI (04), RDSR1 -> 0x00.
- PP 02 00 00 01 A5 without WREN -> after PROG_CYCLES, READ 0x000000 -> FF FF FF, Mem[1]=FF.
- WREN; PP 02 00 00 01 A5; RDSR1 immediately -> 0x03; after PROG_CYCLES RDSR1 -> 0x00; READ 03 00 00 00 -> FF A5 FF; Mem[1]=A5.
- WREN; PP 0x0F to 0x000001 -> READ byte 1 = 0x05 (AND); PP at 0x0000FF with 11 22 -> Mem[0xFF]=11, Mem[0x00]=22 (page wrap).
- During WIP, send READ/WREN -> ignored, SO=z; with S25FL_SECTOR_ERASE_EN, WREN + 20 00 00 00 -> Mem[0..0xFFF]=FF after ERASE_CYCLES.

Source files
------------

// File: rtl/s25fl256s_spi_flash.sv
// s25fl256s_spi_flash: clk-oversampled SPI NOR flash slave (S25FL256S subset).
// Sector erase (opcode 0x20) is built only when S25FL_SECTOR_ERASE_EN is defined.
`timescale 1ns/1ps
module s25fl256s_spi_flash #(
  parameter int ADDR_W       = 12,
  parameter int PAGE_W       = 8,
  parameter int PROG_CYCLES  = 1000,
  parameter int ERASE_CYCLES = 4000
) (
  input  logic clk,
  input  logic rst,
  input  logic SCK,
  input  logic CSNeg,
  input  logic SI,
  output logic SO,
  input  logic RSTNeg,
  input  logic WPNeg,
  input  logic HOLDNeg
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CMD      = 3'd1;
  localparam logic [2:0] ST_ADDR     = 3'd2;
  localparam logic [2:0] ST_DATA_IN  = 3'd3;
  localparam logic [2:0] ST_DATA_OUT = 3'd4;
  localparam logic [2:0] ST_WAIT     = 3'd5;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR1 = 8'h05;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_PP    = 8'h02;
`ifdef S25FL_SECTOR_ERASE_EN
  localparam logic [7:0] OP_SE    = 8'h20;
`endif

  localparam int CNT_MAX = (PROG_CYCLES > ERASE_CYCLES) ?
                           PROG_CYCLES : ERASE_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int PG = 2 ** PAGE_W;

  // flash array: erased (0xFF) at power-up, never touched by reset
  logic [7:0] Mem [2**ADDR_W] = '{default: 8'hFF};

  logic [1:0] sck_sy, cs_sy, si_sy, rstn_sy;
  logic       sck_q, cs_q;

  // two-flop synchronisers plus one stage of history for edge detection
  always_ff @(posedge clk) begin
    sck_sy  <= {sck_sy[0], SCK};
    cs_sy   <= {cs_sy[0], CSNeg};
    si_sy   <= {si_sy[0], SI};
    rstn_sy <= {rstn_sy[0], RSTNeg};
    sck_q   <= sck_sy[1];
    cs_q    <= cs_sy[1];
  end

  logic rst_i, sck_rise, sck_fall, cs_fall, cs_rise, si_s, cs_s;
  logic unused_pins;

  assign rst_i    = rst | ~rstn_sy[1];
  assign si_s     = si_sy[1];
  assign cs_s     = cs_sy[1];
  assign sck_rise = sck_sy[1] & ~sck_q;
  assign sck_fall = ~sck_sy[1] & sck_q;
  assign cs_fall  = ~cs_s & cs_q;
  assign cs_rise  = cs_s & ~cs_q;
  assign unused_pins = ^{WPNeg, HOLDNeg};

  logic [2:0]             state;
  logic [7:0]             op, sr, obyte;
  logic [4:0]             bcnt;
  logic [ADDR_W-1:0]      addr;
  logic [ADDR_W-PAGE_W-1:0] pg;
  logic [PAGE_W-1:0]      col, prog_idx;
  logic [7:0]             pbuf [PG];
  logic [PG-1:0]          pvld;
  logic                   so_q, so_en, wel, wip, prog_on;
  logic [CW-1:0]          busy_cnt;

  logic [7:0]        rx_byte, sr1;
  logic [ADDR_W-1:0] rx_addr;
  logic              wren_go, wrdi_go, pp_go;

  // next shifted byte/address and the CS-rise commit conditions
  always_comb begin
    rx_byte = {sr[6:0], si_s};
    rx_addr = {addr[ADDR_W-2:0], si_s};
    sr1     = {6'b0, wel, wip};
    wren_go = (state == ST_WAIT) && (op == OP_WREN);
    wrdi_go = (state == ST_WAIT) && (op == OP_WRDI);
    pp_go   = (state == ST_DATA_IN) && wel && (|pvld);
  end

  assign SO = so_en ? so_q : 1'bz;

  // command FSM, page buffer and the timed program/erase engine
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      op       <= '0;
      sr       <= '0;
      obyte    <= '0;
      bcnt     <= '0;
      addr     <= '0;
      pg       <= '0;
      col      <= '0;
      pvld     <= '0;
      so_q     <= 1'b0;
      so_en    <= 1'b0;
      wel      <= 1'b0;
      wip      <= 1'b0;
      prog_on  <= 1'b0;
      prog_idx <= '0;
      busy_cnt <= '0;
    end else begin
      if (prog_on) begin
        if (pvld[prog_idx])
          Mem[{pg, prog_idx}] <= Mem[{pg, prog_idx}] & pbuf[prog_idx];
        if (prog_idx == '1) prog_on <= 1'b0;
        prog_idx <= prog_idx + 1'b1;
      end
      if (wip) begin
        if (busy_cnt == '0) begin
          wip <= 1'b0;
          wel <= 1'b0;
        end else begin
          busy_cnt <= busy_cnt - 1'b1;
        end
      end

      if (cs_rise) begin
        state <= ST_IDLE;
        so_en <= 1'b0;
        bcnt  <= '0;
        unique case (1'b1)
          wren_go: wel <= 1'b1;
          wrdi_go: wel <= 1'b0;
          pp_go: begin
            wip      <= 1'b1;
            busy_cnt <= CW'(PROG_CYCLES - 1);
            prog_on  <= 1'b1;
            prog_idx <= '0;
          end
`ifdef S25FL_SECTOR_ERASE_EN
          (state == ST_WAIT && op == OP_SE && wel): begin
            wip      <= 1'b1;
            busy_cnt <= CW'(ERASE_CYCLES - 1);
            for (int i = 0; i < 2**ADDR_W; i++)
              if ((i >> 12) == (int'(addr) >> 12))
                Mem[ADDR_W'(i)] <= 8'hFF;
          end
`endif
          default: ;
        endcase
      end else if (cs_fall) begin
        state <= ST_CMD;
        bcnt  <= '0;
        op    <= '0;
        so_en <= 1'b0;
      end else if (!cs_s && sck_rise) begin
        case (state)
          ST_CMD: begin
            sr   <= rx_byte;
            bcnt <= bcnt + 1'b1;
            if (bcnt == 5'd7) begin
              bcnt <= '0;
              op   <= rx_byte;
              if (wip && rx_byte != OP_RDSR1) begin
                state <= ST_WAIT;
                op    <= '0;
              end else begin
                case (rx_byte)
                  OP_RDSR1: begin
                    state <= ST_DATA_OUT;
                    obyte <= sr1;
                  end
                  OP_READ, OP_PP: state <= ST_ADDR;
`ifdef S25FL_SECTOR_ERASE_EN
                  OP_SE: state <= ST_ADDR;
`endif
                  default: state <= ST_WAIT;
                endcase
              end
            end
          end
          ST_ADDR: begin
            addr <= rx_addr;
            bcnt <= bcnt + 1'b1;
            if (bcnt == 5'd23) begin
              bcnt <= '0;
              case (op)
                OP_READ: begin
                  state <= ST_DATA_OUT;
                  obyte <= Mem[rx_addr];
                  addr  <= rx_addr + 1'b1;
                end
                OP_PP: begin
                  state <= ST_DATA_IN;
                  pg    <= rx_addr[ADDR_W-1:PAGE_W];
                  col   <= rx_addr[PAGE_W-1:0];
                  pvld  <= '0;
                end
                default: state <= ST_WAIT;
              endcase
            end
          end
          ST_DATA_IN: begin
            sr   <= rx_byte;
            bcnt <= bcnt + 1'b1;
            if (bcnt[2:0] == 3'd7) begin
              bcnt      <= '0;
              pbuf[col] <= rx_byte;
              pvld[col] <= 1'b1;
              col       <= col + 1'b1;
            end
          end
          default: ;
        endcase
      end else if (!cs_s && sck_fall && state == ST_DATA_OUT) begin
        so_q  <= obyte[7];
        so_en <= 1'b1;
        if (bcnt[2:0] == 3'd7) begin
          bcnt <= '0;
          if (op == OP_RDSR1) begin
            obyte <= sr1;
          end else begin
            obyte <= Mem[addr];
            addr  <= addr + 1'b1;
          end
        end else begin
          bcnt  <= bcnt + 1'b1;
          obyte <= {obyte[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_s25fl256s_spi_flash.sv
// tb_s25fl256s_spi_flash: directed vector table, corner sequences and
// randomized page programs checked against a byte-array flash model.
`timescale 1ns/1ps
module tb_s25fl256s_spi_flash;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic SCK = 1'b1;
  logic CSNeg = 1'b1;
  logic SI = 1'b0;
  logic RSTNeg = 1'b1;
  logic WPNeg = 1'b1;
  logic HOLDNeg = 1'b1;
  wire  SO;

  int checks = 0;
  int errors = 0;

  logic [7:0] txb [16];
  logic [7:0] rxb [16];
  logic [7:0] mref [4096];

  typedef struct {
    string       name;
    int          n;
    logic [63:0] tx;
    int          cf;
    int          cn;
    logic [23:0] ex;
    int          w;
  } vec_t;

  vec_t vt[$];

  s25fl256s_spi_flash #(
    .ADDR_W(12), .PAGE_W(8), .PROG_CYCLES(1000), .ERASE_CYCLES(4000)
  ) dut (
    .clk(clk), .rst(rst), .SCK(SCK), .CSNeg(CSNeg), .SI(SI), .SO(SO),
    .RSTNeg(RSTNeg), .WPNeg(WPNeg), .HOLDNeg(HOLDNeg)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // mode-3 master: SI changes on SCK fall, SO sampled just before SCK rise
  task automatic frame(input int n, input int xb);
    CSNeg = 1'b0;
    tick(4);
    for (int k = 0; k < 8 * n + xb; k++) begin
      SCK = 1'b0;
      SI  = txb[k / 8][7 - k % 8];
      tick(5);
      rxb[k / 8][7 - k % 8] = (SO === 1'b1);
      SCK = 1'b1;
      tick(5);
    end
    tick(4);
    CSNeg = 1'b1;
    SI    = 1'b0;
    tick(6);
  endtask

  task automatic cmd1(input logic [7:0] o);
    txb[0] = o;
    frame(1, 0);
  endtask

  task automatic rdsr(output logic [7:0] s);
    txb[0] = 8'h05;
    txb[1] = 8'hFF;
    frame(2, 0);
    s = rxb[1];
  endtask

  task automatic read_at(input logic [23:0] a, input int n);
    txb[0] = 8'h03;
    txb[1] = a[23:16];
    txb[2] = a[15:8];
    txb[3] = a[7:0];
    for (int k = 0; k < n; k++) txb[4 + k] = 8'hFF;
    frame(4 + n, 0);
  endtask

  task automatic pp_hdr(input logic [23:0] a);
    txb[0] = 8'h02;
    txb[1] = a[23:16];
    txb[2] = a[15:8];
    txb[3] = a[7:0];
  endtask

  task automatic add(input string nm, input int n, input logic [63:0] tx,
                     input int cf, input int cn, input logic [23:0] ex,
                     input int w);
    vec_t v;
    v.name = nm;
    v.n    = n;
    v.tx   = tx;
    v.cf   = cf;
    v.cn   = cn;
    v.ex   = ex;
    v.w    = w;
    vt.push_back(v);
  endtask

  logic [7:0]  s;
  logic [11:0] pa, ra, idx;
  int          len, polls;
  bit          do_w;

  initial begin
    for (int i = 0; i < 4096; i++) mref[i] = 8'hFF;

    add("rdsr_rst",   2, 64'h05FF_0000_0000_0000, 1, 1, 24'h000000, 0);
    add("read_ff",    7, 64'h0300_0000_FFFF_FF00, 4, 3, 24'hFFFFFF, 0);
    add("wren",       1, 64'h0600_0000_0000_0000, 0, 0, 24'h0, 0);
    add("rdsr_wel",   2, 64'h05FF_0000_0000_0000, 1, 1, 24'h020000, 0);
    add("wrdi",       1, 64'h0400_0000_0000_0000, 0, 0, 24'h0, 0);
    add("rdsr_wrdi",  2, 64'h05FF_0000_0000_0000, 1, 1, 24'h000000, 0);
    add("pp_nowel",   5, 64'h0200_0001_A500_0000, 0, 0, 24'h0, 1100);
    add("read_nowel", 7, 64'h0300_0000_FFFF_FF00, 4, 3, 24'hFFFFFF, 0);
    add("wren2",      1, 64'h0600_0000_0000_0000, 0, 0, 24'h0, 0);
    add("pp_a5",      5, 64'h0200_0001_A500_0000, 0, 0, 24'h0, 0);
    add("rdsr_busy",  3, 64'h05FF_FF00_0000_0000, 1, 2, 24'h030300, 1100);
    add("rdsr_done",  2, 64'h05FF_0000_0000_0000, 1, 1, 24'h000000, 0);
    add("read_a5",    7, 64'h0300_0000_FFFF_FF00, 4, 3, 24'hFFA5FF, 0);
    add("wren3",      1, 64'h0600_0000_0000_0000, 0, 0, 24'h0, 0);
    add("pp_0f",      5, 64'h0200_0001_0F00_0000, 0, 0, 24'h0, 1100);
    add("read_and",   5, 64'h0300_0001_FF00_0000, 4, 1, 24'h050000, 0);
    add("wren4",      1, 64'h0600_0000_0000_0000, 0, 0, 24'h0, 0);
    add("pp_wrap",    6, 64'h0200_00FF_1122_0000, 0, 0, 24'h0, 1100);
    add("read_pgend", 6, 64'h0300_00FF_FFFF_0000, 4, 2, 24'h11FF00, 0);
    add("read_pg0",   6, 64'h0300_0000_FFFF_0000, 4, 2, 24'h220500, 0);
    add("read_arrwr", 6, 64'h0300_0FFF_FFFF_0000, 4, 2, 24'hFF2200, 0);
    add("read_hiadr", 5, 64'h0312_3001_FF00_0000, 4, 1, 24'h050000, 0);

    tick(6);
    rst = 1'b0;
    tick(6);

    for (int i = 0; i < vt.size(); i++) begin
      for (int j = 0; j < 8; j++) txb[j] = vt[i].tx[63 - 8 * j -: 8];
      frame(vt[i].n, 0);
      for (int j = 0; j < vt[i].cn; j++)
        chk($sformatf("%s[%0d]", vt[i].name, j), 32'(rxb[vt[i].cf + j]),
            32'(vt[i].ex[23 - 8 * j -: 8]));
      tick(vt[i].w);
    end

    chk("mem1", 32'(dut.Mem[1]), 32'h05);
    chk("memff", 32'(dut.Mem[12'hFF]), 32'h11);

    // while programming: READ gives no drive, PP is ignored even with WEL=1
    cmd1(8'h06);
    pp_hdr(24'h000010);
    txb[4] = 8'h00;
    frame(5, 0);
    read_at(24'h000020, 1);
    chk("busy_read_z", 32'(rxb[4]), 32'h00);
    pp_hdr(24'h000020);
    txb[4] = 8'h00;
    frame(5, 0);
    tick(1100);
    rdsr(s);
    chk("busy_end_sr", 32'(s), 32'h00);
    read_at(24'h000010, 1);
    chk("busy_pp_done", 32'(rxb[4]), 32'h00);
    read_at(24'h000020, 1);
    chk("busy_pp_ign", 32'(rxb[4]), 32'hFF);

    // trailing partial byte only: no commit, WEL kept
    cmd1(8'h06);
    pp_hdr(24'h000030);
    txb[4] = 8'h00;
    frame(4, 5);
    rdsr(s);
    chk("partial_sr", 32'(s), 32'h02);
    read_at(24'h000030, 1);
    chk("partial_mem", 32'(rxb[4]), 32'hFF);
    cmd1(8'h04);

    // reset aborts a program in progress
    cmd1(8'h06);
    pp_hdr(24'h000040);
    txb[4] = 8'h00;
    frame(5, 0);
    tick(20);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    rdsr(s);
    chk("rst_abort_sr", 32'(s), 32'h00);

    // pin reset clears WEL
    cmd1(8'h06);
    rdsr(s);
    chk("rstneg_pre", 32'(s), 32'h02);
    RSTNeg = 1'b0;
    tick(4);
    RSTNeg = 1'b1;
    tick(6);
    rdsr(s);
    chk("rstneg_sr", 32'(s), 32'h00);

    cmd1(8'h06);
    txb[0] = 8'h20;
    txb[1] = 8'h00;
    txb[2] = 8'h00;
    txb[3] = 8'h00;
    frame(4, 0);
`ifdef S25FL_SECTOR_ERASE_EN
    rdsr(s);
    chk("erase_sr", 32'(s), 32'h03);
    tick(4100);
    rdsr(s);
    chk("erase_done", 32'(s), 32'h00);
    read_at(24'h000000, 2);
    chk("erase_rd0", 32'(rxb[4]), 32'hFF);
    chk("erase_rd1", 32'(rxb[5]), 32'hFF);
    chk("erase_mem", 32'(dut.Mem[12'hFF]), 32'hFF);
`else
    rdsr(s);
    chk("se_unk_sr", 32'(s), 32'h02);
    read_at(24'h000000, 1);
    chk("se_unk_mem", 32'(rxb[4]), 32'h22);
`endif
    cmd1(8'h04);

    // randomized programs in 0x400..0xBFF against the array model
    for (int it = 0; it < 12; it++) begin
      do_w = ($urandom_range(3) != 0);
      pa   = 12'h400 + 12'($urandom_range(12'h7FF));
      len  = $urandom_range(6, 1);
      if (do_w) cmd1(8'h06);
      pp_hdr({12'h000, pa});
      for (int k = 0; k < len; k++) txb[4 + k] = 8'($urandom);
      frame(4 + len, 0);
      if (do_w)
        for (int k = 0; k < len; k++) begin
          idx = {pa[11:8], 8'(pa[7:0] + 8'(k))};
          mref[idx] = mref[idx] & txb[4 + k];
        end
      rdsr(s);
      chk("rnd_sr", 32'(s), do_w ? 32'h03 : 32'h00);
      polls = 0;
      while (s[0] && polls < 20) begin
        rdsr(s);
        polls++;
      end
      chk("rnd_wip_clear", 32'(s), 32'h00);
      ra = 12'h400 + 12'($urandom_range(12'h7FB));
      read_at({12'h000, ra}, 4);
      for (int k = 0; k < 4; k++)
        chk($sformatf("rnd_rd@%0h", ra + 12'(k)), 32'(rxb[4 + k]),
            32'(mref[ra + 12'(k)]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
